// File: rtl/mod_line_responder.sv
// Memory-side line responder for the data-cache miss path: serves line fills as
// word bursts and absorbs writeback bursts, both after a fixed access latency.
module mod_line_responder #(
    parameter int unsigned WORDSIZE  = 64,
    parameter int unsigned ADDRSIZE  = 64,
    parameter int unsigned LOG_WIDTH = 7,
    parameter int unsigned LOG_LINES = 10,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDRSIZE-1:0] req_addr,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [WORDSIZE-1:0] wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSIZE-1:0] rsp_data,
    output logic                rsp_last,
    output logic                rsp_is_wack,
    output logic                busy
);

    localparam int unsigned BEATS  = ((1 << LOG_WIDTH) * 8) / WORDSIZE;
    localparam int unsigned LINES  = 1 << LOG_LINES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_LO = LOG_WIDTH;
    localparam int unsigned IDX_HI = LOG_WIDTH + LOG_LINES - 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WAIT,
        RBURST,
        WACK
    } state_t;

    state_t               state;
    logic [LOG_LINES-1:0] line;
    logic                 is_write;
    logic [BEAT_W-1:0]    beat;
    logic [LAT_W-1:0]     lat_cnt;

    logic [WORDSIZE-1:0]  mem [LINES][BEATS];

    logic                 req_fire_c;
    logic                 wdata_fire_c;
    logic                 rsp_fire_c;
    logic [LOG_LINES-1:0] rd_line_c;
    logic [BEAT_W-1:0]    rd_beat_c;
    logic [WORDSIZE-1:0]  rd_word_c;
    logic                 unused_addr_bits_c;

    assign req_fire_c   = req_valid & req_ready;
    assign wdata_fire_c = wdata_valid & wdata_ready;
    assign rsp_fire_c   = rsp_valid & rsp_ready;

    // Offset bits and bits above the store index alias away.
    assign unused_addr_bits_c = ^{req_addr[ADDRSIZE-1:IDX_HI+1], req_addr[IDX_LO-1:0]};

    // Word the response register loads next: beat 0 when a burst starts, beat+1 while advancing.
    always_comb begin
        rd_line_c = line;
        rd_beat_c = '0;
        if (state == IDLE) begin
            rd_line_c = req_addr[IDX_HI:IDX_LO];
        end else if (state == RBURST) begin
            rd_beat_c = beat + 1'b1;
        end
        rd_word_c = mem[rd_line_c][rd_beat_c];
    end

    // Backing store is never cleared; beats accepted before a reset persist.
    always_ff @(posedge clk) begin
        if (reset_n && wdata_fire_c) begin
            mem[line][beat] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            line        <= '0;
            is_write    <= 1'b0;
            beat        <= '0;
            lat_cnt     <= '0;
            req_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_last    <= 1'b0;
            rsp_is_wack <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_fire_c) begin
                        line      <= req_addr[IDX_HI:IDX_LO];
                        is_write  <= req_write;
                        beat      <= '0;
                        lat_cnt   <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_write) begin
                            state       <= WDATA;
                            wdata_ready <= 1'b1;
                        end else if (LATENCY == 0) begin
                            state     <= RBURST;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rd_word_c;
                            rsp_last  <= (LAST_BEAT == '0);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WDATA: begin
                    if (wdata_fire_c) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            beat        <= '0;
                            wdata_ready <= 1'b0;
                            if (LATENCY == 0) begin
                                state       <= WACK;
                                rsp_valid   <= 1'b1;
                                rsp_data    <= '0;
                                rsp_last    <= 1'b1;
                                rsp_is_wack <= 1'b1;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                end

                WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LAST_WAIT) begin
                        lat_cnt   <= '0;
                        rsp_valid <= 1'b1;
                        if (is_write) begin
                            state       <= WACK;
                            rsp_data    <= '0;
                            rsp_last    <= 1'b1;
                            rsp_is_wack <= 1'b1;
                        end else begin
                            state    <= RBURST;
                            rsp_data <= rd_word_c;
                            rsp_last <= (LAST_BEAT == '0);
                        end
                    end
                end

                // Data and last flag only move on a handshake, so stalls hold them.
                RBURST: begin
                    if (rsp_fire_c) begin
                        if (beat == LAST_BEAT) begin
                            state     <= IDLE;
                            beat      <= '0;
                            rsp_valid <= 1'b0;
                            rsp_data  <= '0;
                            rsp_last  <= 1'b0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            beat     <= rd_beat_c;
                            rsp_data <= rd_word_c;
                            rsp_last <= (rd_beat_c == LAST_BEAT);
                        end
                    end
                end

                WACK: begin
                    if (rsp_fire_c) begin
                        state       <= IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_last    <= 1'b0;
                        rsp_is_wack <= 1'b0;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
